// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared SRAM frame layout, writer states and size helper
package memory_pkg;

   // Frame layout in the SRAM: byte count at address 0, payload from address 1
   localparam int COUNT_ADDR     = 0;
   localparam int DATA_BASE_ADDR = 1;

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      FULL,
      COMMIT,
      FINISH,
      DONE
   } wr_state_e;

   // Largest payload that fits both the address space (minus the count slot)
   // and the count word itself
   function automatic int max_bytes(input int addr_width, input int data_width);
      int addr_lim;
      int data_lim;
      addr_lim = (1 << addr_width) - 1;
      data_lim = (1 << data_width) - 1;
      return (addr_lim < data_lim) ? addr_lim : data_lim;
   endfunction

endpackage

// File: rtl/memory_writer.sv
// rtl/memory_writer.sv - streaming length-prefixed frame writer into single-port SRAM
module memory_writer
   import memory_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   input  logic                  last_in,
   output logic                  ready,
   output logic                  done,
   output logic                  overflow,
   output logic [DATA_WIDTH-1:0] count,
   output logic                  csb0,
   output logic                  web0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0
);

   localparam logic [DATA_WIDTH-1:0] MAX_COUNT =
      DATA_WIDTH'(max_bytes(ADDR_WIDTH, DATA_WIDTH));

   wr_state_e             state_q, state_d;
   logic                  ready_q, ready_d;
   logic                  done_q, done_d;
   logic                  overflow_q, overflow_d;
   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic                  csb0_q, csb0_d;
   logic                  web0_q, web0_d;
   logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
   logic [DATA_WIDTH-1:0] din0_q, din0_d;
   logic [DATA_WIDTH-1:0] count_inc;
   logic                  accept;

   // ready_q is only ever high in RECV, so this is the RECV accept condition
   assign accept    = valid_in && ready_q;
   assign count_inc = count_q + DATA_WIDTH'(1);

   // Next-state and registered-output logic; SRAM strobes idle high unless writing
   always_comb begin
      state_d    = state_q;
      ready_d    = ready_q;
      done_d     = done_q;
      overflow_d = overflow_q;
      count_d    = count_q;
      csb0_d     = 1'b1;
      web0_d     = 1'b1;
      addr0_d    = addr0_q;
      din0_d     = din0_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               count_d    = '0;
               overflow_d = 1'b0;
               ready_d    = 1'b1;
               state_d    = RECV;
            end
         end

         RECV: begin
            if (accept) begin
               csb0_d  = 1'b0;
               web0_d  = 1'b0;
               addr0_d = ADDR_WIDTH'(count_q) + ADDR_WIDTH'(DATA_BASE_ADDR);
               din0_d  = data_in;
               count_d = count_inc;
               if (last_in) begin
                  ready_d = 1'b0;
                  state_d = COMMIT;
               end else if (count_inc == MAX_COUNT) begin
                  ready_d = 1'b0;
                  state_d = FULL;
               end
            end
         end

         // Buffer exhausted: swallow beats until the frame's last one arrives
         FULL: begin
            ready_d = 1'b0;
            if (valid_in) begin
               overflow_d = 1'b1;
               if (last_in) begin
                  state_d = COMMIT;
               end
            end
         end

         COMMIT: begin
            csb0_d  = 1'b0;
            web0_d  = 1'b0;
            addr0_d = ADDR_WIDTH'(COUNT_ADDR);
            din0_d  = count_q;
            state_d = FINISH;
         end

         FINISH: begin
            done_d  = 1'b1;
            state_d = DONE;
         end

         // Hold results until start is released, so a held start cannot re-trigger
         DONE: begin
            if (!start) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         count_q    <= '0;
         csb0_q     <= 1'b1;
         web0_q     <= 1'b1;
         addr0_q    <= '0;
         din0_q     <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
         count_q    <= count_d;
         csb0_q     <= csb0_d;
         web0_q     <= web0_d;
         addr0_q    <= addr0_d;
         din0_q     <= din0_d;
      end
   end

   assign ready    = ready_q;
   assign done     = done_q;
   assign overflow = overflow_q;
   assign count    = count_q;
   assign csb0     = csb0_q;
   assign web0     = web0_q;
   assign addr0    = addr0_q;
   assign din0     = din0_q;

endmodule

// File: tb/tb_memory_writer.sv
// tb/tb_memory_writer.sv - self-checking bench for memory_writer with SRAM model
module tb_memory_writer;

   localparam int MAXB = 255;

   logic       clk;
   logic       resetn;
   logic       start;
   logic [7:0] data_in;
   logic       valid_in;
   logic       last_in;
   logic       ready;
   logic       done;
   logic       overflow;
   logic [7:0] count;
   logic       csb0;
   logic       web0;
   logic [7:0] addr0;
   logic [7:0] din0;

   int vectors;
   int miscompares;

   logic [7:0] mem [256];
   int         writes;

   logic [7:0] exp_mem [256];
   bit         exp_valid [256];
   logic [7:0] fb [$];

   memory_writer dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .data_in  (data_in),
      .valid_in (valid_in),
      .last_in  (last_in),
      .ready    (ready),
      .done     (done),
      .overflow (overflow),
      .count    (count),
      .csb0     (csb0),
      .web0     (web0),
      .addr0    (addr0),
      .din0     (din0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port SRAM: write on rising edge when both strobes low
   initial writes = 0;
   always @(posedge clk) begin
      if (!csb0 && !web0) begin
         mem[addr0] <= din0;
         writes = writes + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, ready, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_overflow"}, overflow, 0);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_csb0"}, csb0, 1);
      chk({tag, "_web0"}, web0, 1);
      chk({tag, "_addr0"}, addr0, 0);
      chk({tag, "_din0"}, din0, 0);
   endtask

   // Compare every SRAM location whose content the model knows
   task automatic chk_mem(input string tag);
      for (int a = 0; a < 256; a++) begin
         if (exp_valid[a]) begin
            chk($sformatf("%s_mem[%0d]", tag, a), mem[a], exp_mem[a]);
         end
      end
   endtask

   // Drive frame fb (last_in on its final beat) and check the whole transaction
   task automatic send_frame(input string tag, input int bubble_pct);
      int n;
      int acc;
      int exp_n;
      int base;
      n     = fb.size();
      acc   = 0;
      exp_n = (n > MAXB) ? MAXB : n;
      base  = writes;
      start = 1'b1;
      step();
      chk({tag, "_ready_start"}, ready, 1);
      chk({tag, "_count_start"}, count, 0);
      chk({tag, "_ovf_start"}, overflow, 0);
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(99) < bubble_pct) begin
            valid_in = 1'b0;
            data_in  = 8'($urandom);
            last_in  = 1'($urandom);
            step();
            chk({tag, "_bubble_csb0"}, csb0, 1);
            chk({tag, "_bubble_web0"}, web0, 1);
         end
         chk({tag, "_ready_pre"}, ready, (acc < MAXB) ? 1 : 0);
         valid_in = 1'b1;
         data_in  = fb[i];
         last_in  = (i == n - 1);
         step();
         if (acc < MAXB) begin
            chk({tag, "_wr_csb0"}, csb0, 0);
            chk({tag, "_wr_web0"}, web0, 0);
            chk({tag, "_wr_addr0"}, addr0, acc + 1);
            chk({tag, "_wr_din0"}, din0, fb[i]);
            exp_mem[acc + 1]   = fb[i];
            exp_valid[acc + 1] = 1'b1;
            acc++;
         end else begin
            chk({tag, "_drop_csb0"}, csb0, 1);
         end
      end
      valid_in = 1'b0;
      last_in  = 1'b0;
      data_in  = 8'($urandom);
      chk({tag, "_done_e0"}, done, 0);
      step();
      chk({tag, "_cnt_csb0"}, csb0, 0);
      chk({tag, "_cnt_web0"}, web0, 0);
      chk({tag, "_cnt_addr0"}, addr0, 0);
      chk({tag, "_cnt_din0"}, din0, exp_n);
      chk({tag, "_done_e1"}, done, 0);
      step();
      chk({tag, "_done_e2"}, done, 1);
      chk({tag, "_count"}, count, exp_n);
      chk({tag, "_overflow"}, overflow, (n > MAXB) ? 1 : 0);
      chk({tag, "_idle_csb0"}, csb0, 1);
      chk({tag, "_ready_end"}, ready, 0);
      exp_mem[0]   = 8'(exp_n);
      exp_valid[0] = 1'b1;
      chk({tag, "_writes"}, writes - base, exp_n + 1);
      chk_mem(tag);
   endtask

   task automatic release_start(input string tag);
      start = 1'b0;
      step();
      chk({tag, "_done_low"}, done, 0);
   endtask

   task automatic rand_frame(input int n);
      fb.delete();
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      for (int a = 0; a < 256; a++) begin
         exp_mem[a]   = 8'h00;
         exp_valid[a] = 1'b0;
      end
      resetn   = 1'b0;
      start    = 1'b0;
      valid_in = 1'b0;
      last_in  = 1'b0;
      data_in  = 8'h00;
      step();
      step();
      chk_reset_outputs("reset");
      resetn = 1'b1;
      step();
      chk_reset_outputs("idle");

      // Basic 3-byte frame
      fb = '{8'hA1, 8'hB2, 8'hC3};
      send_frame("f3", 0);
      release_start("f3");

      // Same frame with valid bubbles
      send_frame("f3b", 50);
      release_start("f3b");

      // Single byte frame
      fb = '{8'h5A};
      send_frame("f1", 0);
      release_start("f1");

      // 255 bytes without last, then two dropped beats, last on the second
      rand_frame(MAXB + 2);
      send_frame("full", 0);
      release_start("full");

      // start held through DONE: no retrigger
      rand_frame(5);
      send_frame("hold", 20);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("hold_done", done, 1);
         chk("hold_ready", ready, 0);
         chk("hold_csb0", csb0, 1);
         chk("hold_count", count, 5);
      end
      release_start("hold");
      rand_frame(7);
      send_frame("second", 20);
      release_start("second");

      // Randomized frames with bubbles
      for (int r = 0; r < 6; r++) begin
         rand_frame($urandom_range(1, 24));
         send_frame($sformatf("rnd%0d", r), 30);
         release_start("rnd");
      end

      // Reset after two of four bytes, then a clean four-byte frame
      rand_frame(4);
      start = 1'b1;
      step();
      for (int i = 0; i < 2; i++) begin
         valid_in = 1'b1;
         data_in  = fb[i];
         last_in  = 1'b0;
         step();
      end
      resetn = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      valid_in = 1'b0;
      start    = 1'b0;
      step();
      resetn = 1'b1;
      step();
      chk_reset_outputs("postrst");
      rand_frame(4);
      send_frame("afterrst", 0);
      release_start("afterrst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard bound on run time in case the DUT stalls the sequence
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
